// File: rtl/arbitro_ultrassom.sv
// arbitro_ultrassom: shares one ultrasonic ranging engine between the water-level
// sensor and the cup sensor. Requests are latched, arbitrated round-robin, and
// each measurement is trigger -> echo width -> result/timeout -> quiet interval.
//
// Request/result handshake: a pedido_* cycle only sets a sticky pending flag and
// is never refused. Each served request ends in exactly one single-cycle pulse,
// either pronto_* (distancia valid) or timeout_* (distancia = all ones).
// distancia changes only on the edge that raises that pulse.
module arbitro_ultrassom #(
    parameter int TRIGGER_CICLOS   = 500,
    parameter int TICK_CM          = 2941,
    parameter int TIMEOUT_CICLOS   = 1500000,
    parameter int INTERVALO_CICLOS = 3000000,
    parameter int DW               = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pedido_agua,
    input  logic          pedido_xicara,
    input  logic          echo_agua,
    input  logic          echo_xicara,
    output logic          trigger_agua,
    output logic          trigger_xicara,
    output logic [DW-1:0] distancia,
    output logic          pronto_agua,
    output logic          pronto_xicara,
    output logic          timeout_agua,
    output logic          timeout_xicara,
    output logic [2:0]    db_estado
);
    localparam int TW = $clog2(TRIGGER_CICLOS) + 1;
    localparam int KW = $clog2(TICK_CM) + 1;
    localparam int OW = $clog2(TIMEOUT_CICLOS) + 1;
    localparam int IW = $clog2(INTERVALO_CICLOS) + 1;

    localparam logic SEL_AGUA   = 1'b0;
    localparam logic SEL_XICARA = 1'b1;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        TRIGGER     = 3'd1,
        ESPERA_ECHO = 3'd2,
        MEDE        = 3'd3,
        RESULTADO   = 3'd4,
        FALHA       = 3'd5,
        INTERVALO   = 3'd6
    } estado_t;

    estado_t        state_q, state_d;
    logic           sel_q, sel_d;
    logic           ultimo_q, ultimo_d;
    logic           pend_agua_q, pend_agua_d;
    logic           pend_xicara_q, pend_xicara_d;
    logic           viu_baixo_q, viu_baixo_d;
    logic [TW-1:0]  trig_cnt_q, trig_cnt_d;
    logic [OW-1:0]  tmo_q, tmo_d;
    logic [KW-1:0]  tick_q, tick_d;
    logic [DW-1:0]  dist_q, dist_d;
    logic [IW-1:0]  int_cnt_q, int_cnt_d;
    logic           trig_agua_q, trig_agua_d;
    logic           trig_xicara_q, trig_xicara_d;
    logic           pronto_agua_q, pronto_agua_d;
    logic           pronto_xicara_q, pronto_xicara_d;
    logic           tmo_agua_q, tmo_agua_d;
    logic           tmo_xicara_q, tmo_xicara_d;
    logic [DW-1:0]  distancia_q, distancia_d;
    logic           escolha;
    logic           echo_sel;

    // Only the echo of the sensor being served is ever looked at.
    assign echo_sel = (sel_q == SEL_XICARA) ? echo_xicara : echo_agua;

    // Next-state logic: arbitration, measurement counters and registered outputs.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        ultimo_d      = ultimo_q;
        pend_agua_d   = pend_agua_q | pedido_agua;
        pend_xicara_d = pend_xicara_q | pedido_xicara;
        viu_baixo_d   = viu_baixo_q;
        trig_cnt_d    = trig_cnt_q;
        tmo_d         = tmo_q;
        tick_d        = tick_q;
        dist_d        = dist_q;
        int_cnt_d     = int_cnt_q;
        escolha       = ~ultimo_q;

        case (state_q)
            OCIOSO: begin
                if (pend_agua_q || pend_xicara_q) begin
                    // On a tie the sensor not served last wins; otherwise the lone requester.
                    if (pend_agua_q && pend_xicara_q) escolha = ~ultimo_q;
                    else                              escolha = pend_xicara_q;
                    sel_d      = escolha;
                    ultimo_d   = escolha;
                    trig_cnt_d = '0;
                    state_d    = TRIGGER;
                    // A request in this very cycle survives and earns another measurement.
                    if (escolha == SEL_AGUA) pend_agua_d   = pedido_agua;
                    else                     pend_xicara_d = pedido_xicara;
                end
            end
            TRIGGER: begin
                if (trig_cnt_q == TW'(TRIGGER_CICLOS - 1)) begin
                    state_d     = ESPERA_ECHO;
                    tmo_d       = '0;
                    viu_baixo_d = 1'b0;
                end else begin
                    trig_cnt_d = trig_cnt_q + 1'b1;
                end
            end
            ESPERA_ECHO: begin
                if (tmo_q == OW'(TIMEOUT_CICLOS - 1)) begin
                    state_d = FALHA;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    // An echo already high on entry must drop before a rise counts.
                    if (echo_sel && viu_baixo_q) begin
                        state_d = MEDE;
                        tick_d  = '0;
                        dist_d  = '0;
                    end else if (!echo_sel) begin
                        viu_baixo_d = 1'b1;
                    end
                end
            end
            MEDE: begin
                if (!echo_sel) begin
                    state_d = RESULTADO;
                end else if (tmo_q == OW'(TIMEOUT_CICLOS - 1)) begin
                    state_d = FALHA;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tick_q == KW'(TICK_CM - 1)) begin
                        tick_d = '0;
                        if (dist_q != {DW{1'b1}}) dist_d = dist_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            RESULTADO, FALHA: begin
                state_d   = INTERVALO;
                int_cnt_d = '0;
            end
            INTERVALO: begin
                if (int_cnt_q == IW'(INTERVALO_CICLOS - 1)) state_d = OCIOSO;
                else                                         int_cnt_d = int_cnt_q + 1'b1;
            end
            default: state_d = OCIOSO;
        endcase

        // Outputs are registered from the state being entered so they align with it.
        trig_agua_d     = (state_d == TRIGGER)   && (sel_d == SEL_AGUA);
        trig_xicara_d   = (state_d == TRIGGER)   && (sel_d == SEL_XICARA);
        pronto_agua_d   = (state_d == RESULTADO) && (sel_d == SEL_AGUA);
        pronto_xicara_d = (state_d == RESULTADO) && (sel_d == SEL_XICARA);
        tmo_agua_d      = (state_d == FALHA)     && (sel_d == SEL_AGUA);
        tmo_xicara_d    = (state_d == FALHA)     && (sel_d == SEL_XICARA);
        distancia_d     = distancia_q;
        if (state_d == RESULTADO)  distancia_d = dist_q;
        else if (state_d == FALHA) distancia_d = {DW{1'b1}};
    end

    // State and output registers; reset abandons any measurement without a pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= OCIOSO;
            sel_q           <= SEL_AGUA;
            ultimo_q        <= SEL_XICARA;
            pend_agua_q     <= 1'b0;
            pend_xicara_q   <= 1'b0;
            viu_baixo_q     <= 1'b0;
            trig_cnt_q      <= '0;
            tmo_q           <= '0;
            tick_q          <= '0;
            dist_q          <= '0;
            int_cnt_q       <= '0;
            trig_agua_q     <= 1'b0;
            trig_xicara_q   <= 1'b0;
            pronto_agua_q   <= 1'b0;
            pronto_xicara_q <= 1'b0;
            tmo_agua_q      <= 1'b0;
            tmo_xicara_q    <= 1'b0;
            distancia_q     <= '0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            ultimo_q        <= ultimo_d;
            pend_agua_q     <= pend_agua_d;
            pend_xicara_q   <= pend_xicara_d;
            viu_baixo_q     <= viu_baixo_d;
            trig_cnt_q      <= trig_cnt_d;
            tmo_q           <= tmo_d;
            tick_q          <= tick_d;
            dist_q          <= dist_d;
            int_cnt_q       <= int_cnt_d;
            trig_agua_q     <= trig_agua_d;
            trig_xicara_q   <= trig_xicara_d;
            pronto_agua_q   <= pronto_agua_d;
            pronto_xicara_q <= pronto_xicara_d;
            tmo_agua_q      <= tmo_agua_d;
            tmo_xicara_q    <= tmo_xicara_d;
            distancia_q     <= distancia_d;
        end
    end

    assign trigger_agua   = trig_agua_q;
    assign trigger_xicara = trig_xicara_q;
    assign pronto_agua    = pronto_agua_q;
    assign pronto_xicara  = pronto_xicara_q;
    assign timeout_agua   = tmo_agua_q;
    assign timeout_xicara = tmo_xicara_q;
    assign distancia      = distancia_q;
    assign db_estado      = state_q;
endmodule

// File: tb/tb_arbitro_ultrassom.sv
// Testbench for arbitro_ultrassom: directed and randomised measurements, each
// outcome predicted from echo timing with plain arithmetic.
module tb_arbitro_ultrassom;
    localparam int TRIG   = 4;
    localparam int TICK   = 10;
    localparam int TMO    = 200;
    localparam int INTERV = 50;
    localparam int DW     = 9;
    // Pulse cycle -> next trigger: one RESULTADO/FALHA-to-INTERVALO step, the quiet
    // interval, and one arbitration cycle in OCIOSO.
    localparam int GAP    = INTERV + 2;

    // ---------------- clock / reset block ----------------
    logic          clock = 1'b0;
    logic          reset;
    logic          pedido_agua, pedido_xicara;
    logic          echo_agua, echo_xicara;
    logic          trigger_agua, trigger_xicara;
    logic [DW-1:0] distancia;
    logic          pronto_agua, pronto_xicara;
    logic          timeout_agua, timeout_xicara;
    logic [2:0]    db_estado;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    arbitro_ultrassom #(
        .TRIGGER_CICLOS  (TRIG),
        .TICK_CM         (TICK),
        .TIMEOUT_CICLOS  (TMO),
        .INTERVALO_CICLOS(INTERV),
        .DW              (DW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pedido_agua   (pedido_agua),
        .pedido_xicara (pedido_xicara),
        .echo_agua     (echo_agua),
        .echo_xicara   (echo_xicara),
        .trigger_agua  (trigger_agua),
        .trigger_xicara(trigger_xicara),
        .distancia     (distancia),
        .pronto_agua   (pronto_agua),
        .pronto_xicara (pronto_xicara),
        .timeout_agua  (timeout_agua),
        .timeout_xicara(timeout_xicara),
        .db_estado     (db_estado)
    );

    // ---------------- scoreboard state ----------------
    int            total = 0;
    int            bad   = 0;
    int            t_pulso = 0;
    int            ult = 1;            // model: last sensor served (0 water, 1 cup)
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic trig(input int s);
        return (s == 0) ? trigger_agua : trigger_xicara;
    endfunction

    function automatic logic pronto(input int s);
        return (s == 0) ? pronto_agua : pronto_xicara;
    endfunction

    function automatic logic falha(input int s);
        return (s == 0) ? timeout_agua : timeout_xicara;
    endfunction

    // Round-robin rule: on a tie the sensor not served last goes first.
    function automatic int escolhe(input bit pa, input bit px);
        if (pa && px) return (ult == 0) ? 1 : 0;
        return pa ? 0 : 1;
    endfunction

    task automatic set_echo(input int s, input logic v_sel, input logic v_out);
        if (s == 0) begin echo_agua = v_sel; echo_xicara = v_out; end
        else        begin echo_xicara = v_sel; echo_agua = v_out; end
    endtask

    task automatic aplicar_reset();
        reset = 1'b1;
        pedido_agua = 1'b0; pedido_xicara = 1'b0;
        echo_agua = 1'b0; echo_xicara = 1'b0;
        step();
        step();
        reset = 1'b0;
        ult = 1;
    endtask

    task automatic pedir(input bit a, input bit x);
        pedido_agua = a; pedido_xicara = x;
        step();
        pedido_agua = 1'b0; pedido_xicara = 1'b0;
    endtask

    task automatic quieto(input string tag, input int n);
        bit ruido = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (trigger_agua || trigger_xicara || pronto_agua || pronto_xicara ||
                timeout_agua || timeout_xicara) ruido = 1'b1;
            step();
        end
        chk(tag, 32'(ruido), 0);
    endtask

    // Serve one measurement of sensor s. After the trigger falls (cycle 0) the
    // echo is low, high on cycles [r, r+h), then low. The other echo is noise.
    task automatic servir(input int s, input int r, input int h, input bit repedir, input int gap);
        int            n, n_hi, pulse_c, n_pulso, outros, c_exp;
        bit            outro_trig, ok, mudou, tipo_pronto;
        logic [DW-1:0] d_antes, d_pulso, d_exp;
        n = 0;
        while (trig(0) == 1'b0 && trig(1) == 1'b0 && n < 400) begin
            step();
            n++;
        end
        chk("trig_sel", 32'(trig(s)), 1);
        if (gap >= 0) chk("trig_gap", cyc - t_pulso, gap);
        n_hi = 0; outro_trig = 1'b0;
        while (trig(s) == 1'b1 && n_hi < 100) begin
            if (trig(1 - s)) outro_trig = 1'b1;
            step();
            n_hi++;
        end
        chk("trig_len", n_hi, TRIG);
        chk("trig_other", 32'(outro_trig), 0);

        // Valid when a rise is seen after a low and the echo is down again before
        // the timeout budget runs out; the rise cycle itself is detection, so the
        // remaining h-1 high cycles are converted to centimetres.
        ok = (r >= 1) && (h >= 1) && (r + h <= TMO - 1);
        if (ok) begin
            c_exp = r + h + 1;
            d_exp = ((h - 1) / TICK > 511) ? DW'(511) : DW'((h - 1) / TICK);
        end else begin
            c_exp = TMO;
            d_exp = {DW{1'b1}};
        end
        exp_q.push_back(d_exp);

        d_antes = distancia; d_pulso = '0; mudou = 1'b0;
        n_pulso = 0; outros = 0; pulse_c = -1; tipo_pronto = 1'b0;
        for (int c = 0; c < TMO + 60; c++) begin
            if (pronto(s) || falha(s)) begin
                n_pulso++;
                if (pulse_c < 0) begin
                    pulse_c = c; tipo_pronto = pronto(s); d_pulso = distancia; t_pulso = cyc;
                end
            end else if (pulse_c < 0 && distancia !== d_antes) begin
                mudou = 1'b1;
            end else if (pulse_c >= 0 && distancia !== d_pulso) begin
                mudou = 1'b1;
            end
            if (pronto(1 - s) || falha(1 - s) || (pronto(s) && falha(s))) outros++;
            if (pulse_c >= 0 && c >= pulse_c + 2) break;
            set_echo(s, (c >= r && c < r + h), 1'($urandom_range(0, 1)));
            if (s == 0) pedido_agua   = repedir && (c == r + 2);
            else        pedido_xicara = repedir && (c == r + 2);
            step();
        end
        set_echo(s, 1'b0, 1'b0);
        pedido_agua = 1'b0; pedido_xicara = 1'b0;

        chk("pulse_kind", 32'(tipo_pronto), 32'(ok));
        chk("pulse_cycle", pulse_c, c_exp);
        chk("pulse_count", n_pulso, 1);
        chk("wrong_pulse", outros, 0);
        chk("dist_hold", 32'(mudou), 0);
        d_exp = exp_q.pop_front();
        chk("distancia", 32'(d_pulso), 32'(d_exp));
        ult = s;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a, p, r, h;
        aplicar_reset();
        chk("rst_estado", 32'(db_estado), 0);
        chk("rst_trig_agua", 32'(trigger_agua), 0);
        chk("rst_trig_xicara", 32'(trigger_xicara), 0);
        chk("rst_distancia", 32'(distancia), 0);
        chk("rst_pulses", 32'({pronto_agua, pronto_xicara, timeout_agua, timeout_xicara}), 0);

        // Single water request, 73-cycle echo, then a quiet interval.
        pedir(1'b1, 1'b0);
        servir(0, 3, 73, 1'b0, -1);
        quieto("interval_quiet", 60);
        chk("idle_estado", 32'(db_estado), 0);

        // Simultaneous requests after reset: water first, then cup; then alternation.
        aplicar_reset();
        pedir(1'b1, 1'b1);
        a = escolhe(1'b1, 1'b1);
        servir(a, $urandom_range(1, 30), $urandom_range(1, 160), 1'b0, -1);
        servir(1 - a, $urandom_range(1, 30), $urandom_range(1, 160), 1'b0, GAP);
        pedir(1'b1, 1'b0);
        servir(escolhe(1'b1, 1'b0), 5, 25, 1'b0, GAP);
        pedir(1'b1, 1'b1);
        a = escolhe(1'b1, 1'b1);
        servir(a, 4, 55, 1'b0, GAP);
        servir(1 - a, 6, 101, 1'b0, GAP);

        // Echo never rises; echo already high on entry; echo stuck high.
        pedir(1'b1, 1'b0);
        servir(0, 5, 0, 1'b0, GAP);
        pedir(1'b0, 1'b1);
        servir(1, 0, 20, 1'b0, GAP);
        pedir(1'b0, 1'b1);
        servir(1, 2, 300, 1'b0, GAP);

        // Echo falls on the last allowed cycle, then one cycle too late.
        pedir(1'b1, 1'b0);
        servir(0, 10, TMO - 11, 1'b0, GAP);
        pedir(1'b1, 1'b0);
        servir(0, 10, TMO - 10, 1'b0, GAP);

        // Request re-asserted while its own measurement runs.
        pedir(1'b1, 1'b0);
        servir(0, 3, 40, 1'b1, GAP);
        servir(0, $urandom_range(1, 30), $urandom_range(1, 160), 1'b0, GAP);

        // Random request patterns and echo timings.
        for (int i = 0; i < 6; i++) begin
            p = $urandom_range(1, 3);
            pedir(p[0], p[1]);
            a = escolhe(p[0], p[1]);
            r = $urandom_range(1, 40);
            h = $urandom_range(1, 220 - r);
            servir(a, r, h, 1'b0, GAP);
            if (p == 3) begin
                r = $urandom_range(1, 40);
                h = $urandom_range(1, 220 - r);
                servir(1 - a, r, h, 1'b0, GAP);
            end
        end

        // Reset while a trigger is high: everything drops, pending request is lost.
        pedir(1'b1, 1'b1);
        p = 0;
        while (!trigger_agua && !trigger_xicara && p < 400) begin
            step();
            p++;
        end
        chk("rst_mid_trig_seen", 32'(trigger_agua | trigger_xicara), 1);
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_trig_agua", 32'(trigger_agua), 0);
        chk("rst_mid_trig_xicara", 32'(trigger_xicara), 0);
        chk("rst_mid_estado", 32'(db_estado), 0);
        chk("rst_mid_distancia", 32'(distancia), 0);
        reset = 1'b0;
        quieto("rst_mid_quiet", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
